// File: rtl/offchip_mem_responder_if.sv
// Bus bundles for the off-chip memory responder: the line-granular port toward
// the memory controller and the 32-bit word-beat port toward external SRAM.
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 16
`endif

interface offchip_mem_if #(
  parameter int LINE_BYTES = `CACHE_LINE_SIZE
);
  logic [31:0]             offchip_mem_addr;
  logic                    offchip_mem_read_en;
  logic                    offchip_mem_write_en;
  logic [LINE_BYTES*8-1:0] offchip_mem_wdata;
  logic [LINE_BYTES*8-1:0] offchip_mem_data;
  logic                    offchip_mem_ready;

  modport master (
    output offchip_mem_addr, offchip_mem_read_en, offchip_mem_write_en, offchip_mem_wdata,
    input  offchip_mem_data, offchip_mem_ready
  );
  modport slave (
    input  offchip_mem_addr, offchip_mem_read_en, offchip_mem_write_en, offchip_mem_wdata,
    output offchip_mem_data, offchip_mem_ready
  );
endinterface

interface ext_mem_if;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;

  modport master (
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ack
  );
  modport slave (
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ack
  );
endinterface

// File: rtl/offchip_mem_responder.sv
// Serves cache-line read/write requests as a burst of 32-bit word beats on an
// SRAM-style bus, assembling read lines and splitting write lines.
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 16
`endif

module offchip_mem_responder #(
  parameter int LINE_BYTES = `CACHE_LINE_SIZE,
  parameter int BEATS      = LINE_BYTES / 4
) (
  input  logic         clk,
  input  logic         rst,
  offchip_mem_if.slave mem,
  ext_mem_if.master    ext
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {IDLE, RD_BEAT, WR_BEAT, DONE} state_t;

  state_t              state, state_nxt;
  logic                rd_q, wr_q;
  logic                rd_pend, wr_pend;
  logic [BEAT_W-1:0]   beat;
  logic [31:0]         line_addr;
  logic [LINE_W-1:0]   wr_line;
  logic [LINE_W-1:0]   rd_buf;
  logic [LINE_W-1:0]   rd_line;
  logic [LINE_W-1:0]   data_q;

  logic rd_eff, wr_eff, start_rd, start_wr, in_beat, last_beat;

  // A rising enable counts immediately, so an idle responder starts on the
  // same edge that records it; otherwise it waits in the sticky flag.
  assign rd_eff    = rd_pend | (mem.offchip_mem_read_en  & ~rd_q);
  assign wr_eff    = wr_pend | (mem.offchip_mem_write_en & ~wr_q);
  assign start_wr  = (state == IDLE) & wr_eff;
  assign start_rd  = (state == IDLE) & ~wr_eff & rd_eff;
  assign in_beat   = (state == RD_BEAT) | (state == WR_BEAT);
  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  // Read buffer with the word arriving this cycle merged in, so the final
  // beat lands in the output register on the same edge that enters DONE.
  always_comb begin
    rd_line = rd_buf;
    rd_line[{beat, 5'b0} +: 32] = ext.ext_rdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_wr)      state_nxt = WR_BEAT;
        else if (start_rd) state_nxt = RD_BEAT;
      end
      RD_BEAT, WR_BEAT: begin
        if (ext.ext_ack && last_beat) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ext.ext_req           = 1'b0;
    ext.ext_we            = 1'b0;
    ext.ext_addr          = 32'h0;
    ext.ext_wdata         = 32'h0;
    mem.offchip_mem_ready = 1'b0;
    case (state)
      RD_BEAT: begin
        ext.ext_req  = 1'b1;
        ext.ext_addr = line_addr + 32'({beat, 2'b00});
      end
      WR_BEAT: begin
        ext.ext_req   = 1'b1;
        ext.ext_we    = 1'b1;
        ext.ext_addr  = line_addr + 32'({beat, 2'b00});
        ext.ext_wdata = wr_line[{beat, 5'b0} +: 32];
      end
      DONE:    mem.offchip_mem_ready = 1'b1;
      default: ;
    endcase
  end

  assign mem.offchip_mem_data = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
      beat    <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      rd_q    <= mem.offchip_mem_read_en;
      wr_q    <= mem.offchip_mem_write_en;
      rd_pend <= rd_eff & ~start_rd;
      wr_pend <= wr_eff & ~start_wr;
      if (start_rd || start_wr)       beat <= '0;
      else if (in_beat && ext.ext_ack) beat <= beat + 1'b1;
      if (state == RD_BEAT && ext.ext_ack && last_beat) data_q <= rd_line;
    end
  end

  // Line address, write line and partial read words carry no reset: each
  // transfer reloads them before they are consumed.
  always_ff @(posedge clk) begin
    if (start_rd || start_wr) line_addr <= mem.offchip_mem_addr & 32'hFFFF_FFF0;
    if (start_wr)             wr_line   <= mem.offchip_mem_wdata;
    if (state == RD_BEAT && ext.ext_ack) rd_buf <= rd_line;
  end

endmodule
